// File: rtl/toy_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_rwport : single read/write memory port (8-bit word address, 16-bit data)
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_rwport;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        val;
  logic        wen;
  logic [15:0] rdata;

  modport master (output addr, output wdata, output val, output wen, input rdata);
  modport slave  (input addr, input wdata, input val, input wen, output rdata);
endinterface
`default_nettype wire

// File: rtl/toy_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// toy_loader : byte-stream program loader / memory examiner for the TOY machine
// Optional burst checksum + ACK/NAK reply: define LOADER_CKSUM_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module toy_loader #(
  parameter int WIPE_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  mem_rwport.master   mem,
  output logic        busy_o,
  output logic        err_o
);

  localparam int c_WIPE_W = (WIPE_CYCLES > 1) ? $clog2(WIPE_CYCLES) : 1;
  localparam logic [c_WIPE_W-1:0] c_WIPE_LAST = c_WIPE_W'(WIPE_CYCLES - 1);
  localparam logic [7:0] c_CMD_W = 8'h57;
  localparam logic [7:0] c_CMD_R = 8'h52;
  localparam logic [7:0] c_CMD_B = 8'h42;

  typedef enum logic [3:0] {
    S_WAIT_CLR, S_IDLE, S_GET_ADDR, S_GET_CNT, S_GET_HI, S_GET_LO,
    S_WRITE, S_READ_REQ, S_READ_WAIT, S_SEND_HI, S_SEND_LO
`ifdef LOADER_CKSUM_EN
    , S_CK, S_SEND_CK
`endif
  } state_t;

  state_t              r_state, w_next;
  logic [c_WIPE_W-1:0] r_wipe;
  logic [7:0]          r_cmd;
  logic [7:0]          r_addr;
  logic [7:0]          r_hi;
  logic [8:0]          r_remain;
  logic [15:0]         r_rd;
  logic                r_err;
  logic [7:0]          r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic                w_acc;
  logic                w_cmd_ok;
`ifdef LOADER_CKSUM_EN
  logic [7:0]          r_sum;
  logic [7:0]          r_ack;
`endif

  assign w_acc    = rx_valid_i && rx_ready_o;
  assign w_cmd_ok = (rx_data_i == c_CMD_W) || (rx_data_i == c_CMD_R) || (rx_data_i == c_CMD_B);

  always_comb begin
    w_next     = r_state;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    case (r_state)
      S_WAIT_CLR:  if (r_wipe == c_WIPE_LAST) w_next = S_IDLE;
      S_IDLE: begin
        rx_ready_o = 1'b1;
        if (w_acc && w_cmd_ok) w_next = S_GET_ADDR;
      end
      S_GET_ADDR: begin
        rx_ready_o = 1'b1;
        if (w_acc) begin
          if (r_cmd == c_CMD_R)      w_next = S_READ_REQ;
          else if (r_cmd == c_CMD_B) w_next = S_GET_CNT;
          else                       w_next = S_GET_HI;
        end
      end
      S_GET_CNT: begin
        rx_ready_o = 1'b1;
        if (w_acc) w_next = S_GET_HI;
      end
      S_GET_HI: begin
        rx_ready_o = 1'b1;
        if (w_acc) w_next = S_GET_LO;
      end
      S_GET_LO: begin
        rx_ready_o = 1'b1;
        if (w_acc) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (r_cmd != c_CMD_B) w_next = S_IDLE;
        else if (r_remain == 9'd1)
`ifdef LOADER_CKSUM_EN
          w_next = S_CK;
`else
          w_next = S_IDLE;
`endif
        else w_next = S_GET_HI;
      end
      S_READ_REQ:  w_next = S_READ_WAIT;
      S_READ_WAIT: w_next = S_SEND_HI;
      S_SEND_HI: begin
        tx_valid_o = 1'b1;
        tx_data_o  = r_rd[15:8];
        if (tx_ready_i) w_next = S_SEND_LO;
      end
      S_SEND_LO: begin
        tx_valid_o = 1'b1;
        tx_data_o  = r_rd[7:0];
        if (tx_ready_i) w_next = S_IDLE;
      end
`ifdef LOADER_CKSUM_EN
      S_CK: begin
        rx_ready_o = 1'b1;
        if (w_acc) w_next = S_SEND_CK;
      end
      S_SEND_CK: begin
        tx_valid_o = 1'b1;
        tx_data_o  = r_ack;
        if (tx_ready_i) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Address/data registers only load on entry to an access cycle so they hold afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_WAIT_CLR;
      r_wipe      <= '0;
      r_cmd       <= 8'h00;
      r_addr      <= 8'h00;
      r_hi        <= 8'h00;
      r_remain    <= 9'd0;
      r_rd        <= 16'h0000;
      r_err       <= 1'b0;
      r_mem_addr  <= 8'h00;
      r_mem_wdata <= 16'h0000;
`ifdef LOADER_CKSUM_EN
      r_sum       <= 8'h00;
      r_ack       <= 8'h00;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_WAIT_CLR: r_wipe <= r_wipe + 1'b1;
        S_IDLE: if (w_acc) begin
          if (w_cmd_ok) r_cmd <= rx_data_i;
          else          r_err <= 1'b1;
`ifdef LOADER_CKSUM_EN
          r_sum <= 8'h00;
`endif
        end
        S_GET_ADDR: if (w_acc) begin
          r_addr     <= rx_data_i;
          r_mem_addr <= (r_cmd == c_CMD_R) ? rx_data_i : r_mem_addr;
`ifdef LOADER_CKSUM_EN
          r_sum <= r_sum + rx_data_i;
`endif
        end
        S_GET_CNT: if (w_acc) begin
          r_remain <= (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};
`ifdef LOADER_CKSUM_EN
          r_sum <= r_sum + rx_data_i;
`endif
        end
        S_GET_HI: if (w_acc) begin
          r_hi <= rx_data_i;
`ifdef LOADER_CKSUM_EN
          r_sum <= r_sum + rx_data_i;
`endif
        end
        S_GET_LO: if (w_acc) begin
          r_mem_addr  <= r_addr;
          r_mem_wdata <= {r_hi, rx_data_i};
`ifdef LOADER_CKSUM_EN
          r_sum <= r_sum + rx_data_i;
`endif
        end
        S_WRITE: if (r_cmd == c_CMD_B) begin
          r_remain <= r_remain - 9'd1;
          r_addr   <= r_addr + 8'd1;
        end
        S_READ_WAIT: r_rd <= mem.rdata;
`ifdef LOADER_CKSUM_EN
        S_CK: if (w_acc) begin
          r_ack <= (rx_data_i == r_sum) ? 8'h06 : 8'h15;
          if (rx_data_i != r_sum) r_err <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem.val   = (r_state == S_WRITE) || (r_state == S_READ_REQ);
  assign mem.wen   = (r_state == S_WRITE);
  assign mem.addr  = r_mem_addr;
  assign mem.wdata = r_mem_wdata;
  assign busy_o    = (r_state != S_IDLE);
  assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_toy_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_toy_loader : directed self-checking bench for toy_loader
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_toy_loader;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int val_cnt = 0;
  logic [23:0] wq[$];
  logic [15:0] mem_model [256];
  logic [15:0] rw;

  mem_rwport mem_if ();

  toy_loader #(.WIPE_CYCLES(256)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .mem        (mem_if),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears one cycle after the request cycle.
  always @(posedge clk) begin
    if (mem_if.val === 1'b1 && mem_if.wen === 1'b1) mem_model[mem_if.addr] <= mem_if.wdata;
    if (mem_if.val === 1'b1 && mem_if.wen === 1'b0) mem_if.rdata <= mem_model[mem_if.addr];
  end

  always @(posedge clk) begin
    if (mem_if.val === 1'b1) val_cnt <= val_cnt + 1;
    if (mem_if.val === 1'b1 && mem_if.wen === 1'b1) wq.push_back({mem_if.addr, mem_if.wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic read_word(input logic [7:0] a, output logic [15:0] w);
    int n;
    n = 0;
    tx_ready = 1'b1;
    send_byte(8'h52);
    send_byte(a);
    while (tx_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rd_valid_hi", {31'd0, tx_valid}, 32'd1);
    w[15:8] = tx_data;
    @(posedge clk); #1;
    chk("rd_valid_lo", {31'd0, tx_valid}, 32'd1);
    w[7:0] = tx_data;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (256) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_val", {31'd0, mem_if.val}, 32'd0);
    chk("rst_wen", {31'd0, mem_if.wen}, 32'd0);
    chk("rst_addr", {24'd0, mem_if.addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_if.wdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Wipe window
    rst_ni = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    chk("wipe_busy", {31'd0, busy}, 32'd1);
    chk("wipe_rx_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("wipe_no_access", val_cnt, 32'd0);

    // Single write
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34);
    chk("w_val", {31'd0, mem_if.val}, 32'd1);
    chk("w_wen", {31'd0, mem_if.wen}, 32'd1);
    chk("w_addr", {24'd0, mem_if.addr}, 32'h10);
    chk("w_wdata", {16'd0, mem_if.wdata}, 32'h1234);
    @(posedge clk); #1;
    chk("w_done_busy", {31'd0, busy}, 32'd0);
    chk("w_done_val", {31'd0, mem_if.val}, 32'd0);
    chk("w_hold_addr", {24'd0, mem_if.addr}, 32'h10);

    // Read with downstream stall
    send_byte(8'h52); send_byte(8'h10);
    chk("r_req_val", {31'd0, mem_if.val}, 32'd1);
    chk("r_req_wen", {31'd0, mem_if.wen}, 32'd0);
    chk("r_req_tx_valid", {31'd0, tx_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("r_hi_valid", {31'd0, tx_valid}, 32'd1);
    chk("r_hi_data", {24'd0, tx_data}, 32'h12);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("r_hi_hold", {23'd0, tx_valid, tx_data}, 32'h112);
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("r_lo", {23'd0, tx_valid, tx_data}, 32'h134);
    @(posedge clk); #1;
    chk("r_end_valid", {31'd0, tx_valid}, 32'd0);
    chk("r_end_busy", {31'd0, busy}, 32'd0);
    tx_ready = 1'b0;

    // Burst with address wrap (checksum 0x63 in the checksum build)
    wq.delete();
    send_byte(8'h42); send_byte(8'hFE); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hAA);
    send_byte(8'hBB); send_byte(8'hBB);
    send_byte(8'hCC); send_byte(8'hCC);
`ifdef LOADER_CKSUM_EN
    tx_ready = 1'b1;
    send_byte(8'h63);
    chk("b_ack", {23'd0, tx_valid, tx_data}, 32'h106);
    @(posedge clk); #1;
    tx_ready = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("b_count", wq.size(), 32'd3);
    if (wq.size() == 3) begin
      chk("b_w0", {8'd0, wq[0]}, 32'hFEAAAA);
      chk("b_w1", {8'd0, wq[1]}, 32'hFFBBBB);
      chk("b_w2", {8'd0, wq[2]}, 32'h00CCCC);
    end
    chk("b_idle", {31'd0, busy}, 32'd0);
    read_word(8'hFE, rw); chk("rb_fe", {16'd0, rw}, 32'hAAAA);
    read_word(8'hFF, rw); chk("rb_ff", {16'd0, rw}, 32'hBBBB);
    read_word(8'h00, rw); chk("rb_00", {16'd0, rw}, 32'hCCCC);

    // Illegal command
    chk("pre_err", {31'd0, err}, 32'd0);
    send_byte(8'h99);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_idle", {31'd0, busy}, 32'd0);
    send_byte(8'h57); send_byte(8'h20); send_byte(8'h55); send_byte(8'h66);
    chk("post_err_wr", {15'd0, mem_if.val, mem_if.addr, mem_if.wdata[7:0]}, 32'h12066);
    @(posedge clk); #1;
    chk("err_sticky", {31'd0, err}, 32'd1);
    read_word(8'h20, rw); chk("rb_20", {16'd0, rw}, 32'h5566);

    // Reset mid-command discards the partial command and clears err
    send_byte(8'h57); send_byte(8'h30);
    do_reset();
    chk("rst2_err", {31'd0, err}, 32'd0);
    chk("rst2_idle", {31'd0, busy}, 32'd0);
    val_cnt = 0;
    send_byte(8'h52); send_byte(8'h20);
    chk("rst2_read_req", {31'd0, mem_if.val}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_read_hi", {23'd0, tx_valid, tx_data}, 32'h155);
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tx_ready = 1'b0;

`ifdef LOADER_CKSUM_EN
    tx_ready = 1'b1;
    send_byte(8'h42); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
    chk("ck_ok", {23'd0, tx_valid, tx_data}, 32'h106);
    @(posedge clk); #1;
    chk("ck_ok_err", {31'd0, err}, 32'd0);
    send_byte(8'h42); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
    chk("ck_bad", {23'd0, tx_valid, tx_data}, 32'h115);
    @(posedge clk); #1;
    chk("ck_bad_err", {31'd0, err}, 32'd1);
    chk("ck_idle", {31'd0, busy}, 32'd0);
    tx_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
